// File: rtl/fmult_seq_pkg.sv
// Shared constants, float-field layout and FSM encoding for the G.726 FMULT sequencer.
package fmult_seq_pkg;

   localparam int NTERMS = 8;
   localparam int NZERO  = 6;

   localparam int COEF_W = 16;
   localparam int DATA_W = 11;

   localparam int FLT_SIGN     = 10;
   localparam int FLT_EXP_MSB  = 9;
   localparam int FLT_EXP_LSB  = 6;
   localparam int FLT_MANT_MSB = 5;
   localparam int FLT_MANT_LSB = 0;

   localparam logic [15:0] MANT_RND    = 16'd48;
   localparam logic [4:0]  EXP_BIAS    = 5'd26;
   localparam logic [15:0] AN_MAG_MASK = 16'h1FFF;
   localparam logic [31:0] W_MAG_MASK  = 32'h0000_7FFF;
   localparam logic [5:0]  MANT_ZERO   = 6'd32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fmult_seq_core.sv
// Combinational G.726 FMULT: (An, SRn) -> W, exposed as an exponent/mantissa half and a
// scaling half so the sequencer can optionally register the boundary between them.
module fmult_core
   import fmult_seq_pkg::*;
(
   input  logic signed [COEF_W-1:0] an,
   input  logic        [DATA_W-1:0] srn,
   output logic                     prod_s,
   output logic        [4:0]        prod_exp,
   output logic        [7:0]        prod_mant,
   input  logic                     scale_s,
   input  logic        [4:0]        scale_exp,
   input  logic        [7:0]        scale_mant,
   output logic signed [15:0]       w
);

   logic        an_s;
   logic        sr_s;
   logic [15:0] an_abs;
   logic [12:0] an_mag;
   logic [3:0]  an_exp;
   logic [3:0]  sr_exp;
   logic [5:0]  an_mant;
   logic [5:0]  sr_mant;
   logic [11:0] prod;
   logic [14:0] mant_al;
   logic [31:0] scaled;
   logic [14:0] w_mag;

   // Stage 1: coefficient to float, then product sign/exponent/mantissa.
   always_comb begin
      an_s   = an[COEF_W-1];
      an_abs = an_s ? 16'(-an) : 16'(an);
      an_mag = 13'((an_abs >> 2) & AN_MAG_MASK);
      an_exp = '0;
      for (int i = 0; i < 13; i++) begin
         if (an_mag[i]) an_exp = 4'(i + 1);
      end
      an_mant   = (an_mag == '0) ? MANT_ZERO : 6'({an_mag, 6'b0} >> an_exp);
      sr_s      = srn[FLT_SIGN];
      sr_exp    = srn[FLT_EXP_MSB:FLT_EXP_LSB];
      sr_mant   = srn[FLT_MANT_MSB:FLT_MANT_LSB];
      prod_s    = sr_s ^ an_s;
      prod_exp  = {1'b0, sr_exp} + {1'b0, an_exp};
      prod      = 12'(sr_mant) * 12'(an_mant);
      prod_mant = 8'((16'(prod) + MANT_RND) >> 4);
   end

   // Stage 2: align the mantissa by the product exponent and apply the sign.
   always_comb begin
      mant_al = {scale_mant, 7'b0};
      if (scale_exp > EXP_BIAS) scaled = 32'(mant_al) << (scale_exp - EXP_BIAS);
      else                      scaled = 32'(mant_al) >> (EXP_BIAS - scale_exp);
      w_mag = 15'(scaled & W_MAG_MASK);
      w     = scale_s ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
   end

endmodule

// File: rtl/fmult_seq.sv
// Eight-term FMULT sequencer feeding the ADPCM accumulator over valid/ready.
// Define FMULT_PIPE_EN to register the FMULT exponent/mantissa (compute cycle + present cycle per term).
module fmult_seq
   import fmult_seq_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [COEF_W-1:0] b1,
   input  logic signed [COEF_W-1:0] b2,
   input  logic signed [COEF_W-1:0] b3,
   input  logic signed [COEF_W-1:0] b4,
   input  logic signed [COEF_W-1:0] b5,
   input  logic signed [COEF_W-1:0] b6,
   input  logic        [DATA_W-1:0] dq1,
   input  logic        [DATA_W-1:0] dq2,
   input  logic        [DATA_W-1:0] dq3,
   input  logic        [DATA_W-1:0] dq4,
   input  logic        [DATA_W-1:0] dq5,
   input  logic        [DATA_W-1:0] dq6,
   input  logic signed [COEF_W-1:0] a1,
   input  logic signed [COEF_W-1:0] a2,
   input  logic        [DATA_W-1:0] sr1,
   input  logic        [DATA_W-1:0] sr2,
   output logic signed [15:0]       W,
   output logic                     W_valid,
   input  logic                     W_ready,
   output logic                     sez_last,
   output logic                     last,
   output logic                     busy,
   output logic                     done,
   input  logic                     scan_in0,
   input  logic                     scan_in1,
   input  logic                     scan_in2,
   input  logic                     scan_in3,
   input  logic                     scan_in4,
   input  logic                     scan_enable,
   input  logic                     test_mode,
   output logic                     scan_out0,
   output logic                     scan_out1,
   output logic                     scan_out2,
   output logic                     scan_out3,
   output logic                     scan_out4
);

   typedef logic [$clog2(NTERMS)-1:0] idx_t;

   state_t state;
   state_t state_nxt;
   idx_t   idx;
   idx_t   idx_nxt;
   idx_t   sel;
   idx_t   load_idx;
   idx_t   out_idx;
   logic   xfer;
   logic   capture;
   logic   load_term;
   logic   out_load;

   logic signed [COEF_W-1:0] snap_a  [NTERMS];
   logic        [DATA_W-1:0] snap_sr [NTERMS];
   logic signed [COEF_W-1:0] mux_a;
   logic        [DATA_W-1:0] mux_sr;

   logic              prod_s;
   logic [4:0]        prod_exp;
   logic [7:0]        prod_mant;
   logic              scale_s;
   logic [4:0]        scale_exp;
   logic [7:0]        scale_mant;
   logic signed [15:0] w_core;
   logic              dft_unused;

   assign dft_unused = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
   assign scan_out0  = 1'b0;
   assign scan_out1  = 1'b0;
   assign scan_out2  = 1'b0;
   assign scan_out3  = 1'b0;
   assign scan_out4  = 1'b0;

   assign busy = (state == ISSUE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      xfer      = W_valid & W_ready;
      capture   = 1'b0;
      load_term = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ISSUE;
               idx_nxt   = '0;
               capture   = 1'b1;
               load_term = 1'b1;
            end
         end
         ISSUE: begin
            if (xfer) begin
               if (idx == idx_t'(NTERMS - 1)) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt   = idx + idx_t'(1);
                  load_term = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         snap_a  <= '{b1, b2, b3, b4, b5, b6, a1, a2};
         snap_sr <= '{dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2};
      end
   end

   // Term 0 is computed from the live ports in the start cycle, later terms from the snapshot.
   always_comb begin
      sel = idx + idx_t'(1);
      if (capture) begin
         mux_a    = b1;
         mux_sr   = dq1;
         load_idx = '0;
      end else begin
         mux_a    = snap_a[sel];
         mux_sr   = snap_sr[sel];
         load_idx = sel;
      end
   end

   fmult_core u_core (
      .an         (mux_a),
      .srn        (mux_sr),
      .prod_s     (prod_s),
      .prod_exp   (prod_exp),
      .prod_mant  (prod_mant),
      .scale_s    (scale_s),
      .scale_exp  (scale_exp),
      .scale_mant (scale_mant),
      .w          (w_core)
   );

`ifdef FMULT_PIPE_EN
   logic       prod_s_p1;
   logic [4:0] prod_exp_p1;
   logic [7:0] prod_mant_p1;
   logic       vld_p1;

   // p1: exponent/mantissa register; the following cycle is the compute cycle.
   always_ff @(posedge clk) begin
      if (load_term) begin
         prod_s_p1    <= prod_s;
         prod_exp_p1  <= prod_exp;
         prod_mant_p1 <= prod_mant;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_p1 <= 1'b0;
      else        vld_p1 <= load_term;
   end

   assign scale_s    = prod_s_p1;
   assign scale_exp  = prod_exp_p1;
   assign scale_mant = prod_mant_p1;
   assign out_load   = vld_p1;
   assign out_idx    = idx;
`else
   assign scale_s    = prod_s;
   assign scale_exp  = prod_exp;
   assign scale_mant = prod_mant;
   assign out_load   = load_term;
   assign out_idx    = load_idx;
`endif

   // Output register: held until the accumulator takes it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         W        <= '0;
         W_valid  <= 1'b0;
         sez_last <= 1'b0;
         last     <= 1'b0;
      end else if (out_load) begin
         W        <= w_core;
         W_valid  <= 1'b1;
         sez_last <= (out_idx == idx_t'(NZERO - 1));
         last     <= (out_idx == idx_t'(NTERMS - 1));
      end else if (xfer) begin
         W        <= '0;
         W_valid  <= 1'b0;
         sez_last <= 1'b0;
         last     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fmult_seq.sv
// Scoreboard bench for fmult_seq; build with FMULT_PIPE_EN to match the pipelined timing.
module tb_fmult_seq;

`ifdef FMULT_PIPE_EN
   localparam int LAT     = 2;
   localparam int STEP    = 2;
   localparam int STALL_X = 2;
`else
   localparam int LAT     = 1;
   localparam int STEP    = 1;
   localparam int STALL_X = 3;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [15:0] b1, b2, b3, b4, b5, b6, a1, a2;
   logic [10:0] dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2;
   logic [15:0] W;
   logic W_valid;
   logic W_ready = 1'b1;
   logic sez_last, last, busy, done;
   logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

   fmult_seq dut (
      .clk(clk), .reset(reset), .start(start),
      .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
      .dq1(dq1), .dq2(dq2), .dq3(dq3), .dq4(dq4), .dq5(dq5), .dq6(dq6),
      .a1(a1), .a2(a2), .sr1(sr1), .sr2(sr2),
      .W(W), .W_valid(W_valid), .W_ready(W_ready),
      .sez_last(sez_last), .last(last), .busy(busy), .done(done),
      .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
      .scan_enable(1'b0), .test_mode(1'b0),
      .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
      .scan_out3(scan_out3), .scan_out4(scan_out4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] w;
      logic        sez;
      logic        lst;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          done_q[$];
   logic [15:0] exp_w [8];
   int          cyc = 0;
   int          nxfer = 0;
   int          base = 0;
   int          tmo = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic        end_req = 1'b0;
   logic        prev_stall = 1'b0;
   exp_t        head;
   int          dcyc;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Monitor: compares every presented term against the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_W", W, 0);
         chk("rst_W_valid", W_valid, 0);
         chk("rst_sez_last", sez_last, 0);
         chk("rst_last", last, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_scan", {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 0);
         prev_stall = 1'b0;
      end else begin
         if (busy) chk("busy_has_frame", sb.size() > 0, 1);
         if (prev_stall) chk("valid_held", W_valid, 1);
         if (W_valid) begin
            chk("busy_with_valid", busy, 1);
            if (sb.size() == 0) begin
               chk("W_unexpected", W_valid, 0);
            end else begin
               head = sb[0];
               chk("W", W, head.w);
               chk("sez_last", sez_last, head.sez);
               chk("last", last, head.lst);
               if (W_ready) begin
                  if (head.cyc >= 0) chk("xfer_cycle", cyc, head.cyc);
                  nxfer++;
                  void'(sb.pop_front());
               end
            end
         end
         if (done) begin
            chk("busy_at_done", busy, 0);
            if (done_q.size() == 0) chk("done_spurious", done, 0);
            else begin
               dcyc = done_q.pop_front();
               chk("done_cycle", cyc, dcyc);
            end
         end
         prev_stall = W_valid && !W_ready;
         if (end_req) begin
            chk("sb_drained", sb.size(), 0);
            chk("done_drained", done_q.size(), 0);
            chk("timeouts", tmo, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
      end
   end

   task automatic clear_ops();
      b1 = '0; b2 = '0; b3 = '0; b4 = '0; b5 = '0; b6 = '0; a1 = '0; a2 = '0;
      dq1 = 11'h020; dq2 = 11'h020; dq3 = 11'h020; dq4 = 11'h020;
      dq5 = 11'h020; dq6 = 11'h020; sr1 = 11'h020; sr2 = 11'h020;
   endtask

   task automatic set_basic();
      clear_ops();
      b1 = 16'h4000; dq1 = 11'h060;
      exp_w = '{16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
   endtask

   task automatic set_mixed();
      clear_ops();
      b1 = 16'h2000; dq1 = 11'h060;
      b2 = 16'hC000; dq2 = 11'h060;
      b3 = 16'h1234; dq3 = 11'h328;
      a1 = 16'h7FFF; sr1 = 11'h7FF;
      a2 = 16'h7FFF; sr2 = 11'h3FF;
      exp_w = '{16'h0001, 16'hFFFE, 16'h05D0, 16'h0000, 16'h0000, 16'h0000, 16'h8A00, 16'h7600};
   endtask

   task automatic launch(input int stall_x);
      int   n;
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1;
      n     = cyc;
      base  = nxfer;
      for (int i = 0; i < 8; i++) begin
         e.w   = exp_w[i];
         e.sez = (i == 5);
         e.lst = (i == 7);
         e.cyc = n + LAT + STEP * i + ((i >= 2) ? stall_x : 0);
         sb.push_back(e);
      end
      done_q.push_back(n + LAT + STEP * 7 + 1 + stall_x);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_xfers(input int k);
      int t;
      t = 0;
      while ((nxfer - base) < k && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if ((nxfer - base) < k) begin
         tmo++;
         $display("FAIL wait_xfers: got %0d transfers, expected %0d", nxfer - base, k);
      end
   endtask

   initial begin
      clear_ops();
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      set_basic();
      launch(0);
      wait_xfers(8);
      repeat (3) @(posedge clk);
      #1;

      set_mixed();
      launch(0);
      wait_xfers(8);
      repeat (3) @(posedge clk);
      #1;

      set_mixed();
      launch(STALL_X);
      wait_xfers(2);
      W_ready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      W_ready = 1'b1;
      wait_xfers(8);
      repeat (3) @(posedge clk);
      #1;

      set_basic();
      launch(0);
      wait_xfers(1);
      b4 = 16'h4000;
      wait_xfers(3);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_xfers(8);
      repeat (4) @(posedge clk);
      #1;

      set_basic();
      launch(0);
      wait_xfers(4);
      reset = 1'b0;
      sb.delete();
      done_q.delete();
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      launch(0);
      wait_xfers(8);
      repeat (3) @(posedge clk);
      #1;

      end_req = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

endmodule
